des_key_sched_iter: RTL and testbench
=====================================

// Module: des_key_sched_iter
// PURPOSE
//  Iterative DES key scheduler: one 48-bit round key per handshake, generated on the fly.
//  Encrypt mode: K1..K16 via left rotations of C/D. Decrypt mode: K16..K1 via right
//  rotations (inverse schedule), so no 16-key store is needed.
//  Feeds a one-round-per-cycle DES datapath; replaces the fully unrolled 16-key array
//  where area matters.
// PARAMETERS
//  RESTART_EN  0  1: start while busy aborts the current schedule and restarts; 0: ignored
// PORTS
//  clk              in   1   clock
//  rst              in   1   synchronous, active-high reset
//  start            in   1   pulse; capture init_key/encrypt_decrypt, begin schedule
//  init_key         in   64  DES key incl. parity bits (parity ignored)
//  encrypt_decrypt  in   1   0 = encrypt (K1 first), 1 = decrypt (K16 first)
//  key_ready        in   1   consumer accepts round_key this cycle
//  key_valid        out  1   round_key/round_idx valid
//  round_key        out  48  PC-2(C,D) of current state
//  round_idx        out  4   0..15 = DES round number minus 1 of the key presented (K1 -> 0)
//  key_last         out  1   high with final key of schedule (K16 enc / K1 dec)
//  busy             out  1   schedule in progress (includes the cycle with the last key)
// BEHAVIOUR
//  Reset: state=IDLE, key_valid=0, busy=0, key_last=0, round_idx=0, C/D regs=0 (round_key=PC2(0)=0).
//  States: IDLE, RUN.
//  IDLE + start: {C,D} <= PC-1(init_key) then one rotation by sched[0]; mode latched;
//   cnt<=0; -> RUN. key_valid high the next cycle (latency 1).
//  Shift schedule (package const): ENC left  {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
//   DEC right {0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1} (dec step 0 = K16 = PC-2(PC-1(key))).
//   C and D (28 b each) rotate independently, same amount.
//  Handshake: transfer when key_valid & key_ready. round_key, round_idx, key_last
//   hold stable while key_valid & !key_ready. key_valid never drops without transfer.
//  On transfer with cnt<15: cnt++, rotate C/D by sched[cnt+1]. Next key valid next cycle
//   (key_valid stays high: full throughput, 1 key/cycle under constant key_ready).
//  round_idx = enc ? cnt : 15-cnt. key_last = key_valid & (cnt==15).
//  On transfer with cnt==15: -> IDLE; key_valid=0, busy=0 next cycle. start in that
//   same cycle is accepted (back-to-back schedules, no bubble beyond latency 1).
//  start in RUN: RESTART_EN=0 -> ignored, inputs not sampled. RESTART_EN=1 -> reload
//   as from IDLE; pending key discarded even if key_ready high that cycle (no transfer counted).
//  encrypt_decrypt/init_key sampled only on accepted start; changes mid-run ignored.
//  rst mid-RUN: immediate return to reset values next cycle; rst dominates start.
//  Width rules: cnt 4 b, no wrap (terminal at 15). All rotations mod 28.
// STRUCTURE
//  des_pkg: ENC_SHIFT/DEC_SHIFT tables, PC1 and PC2 permutation tables, state enum.
//  Reuse p_box_64_56 for PC-1. One new sub-module: p_box_56_48 (PC-2, combinational).
//  Top: FSM, counter, C/D regs with rotate-left/right by 0/1/2 mux.
// TESTING
//  1 enc, key=133457799BBCDFF1, key_ready=1 -> 16 cycles valid; K1=1B02EFFC7072 idx0,
//    K16=CB3D8B0E17F5 idx15 with key_last; busy low after.
//  2 dec, same key -> first key CB3D8B0E17F5 idx15, last 1B02EFFC7072 idx0 key_last;
//    full sequence equals enc sequence reversed.
//  3 backpressure: random key_ready (~30%) -> outputs stable while stalled; exactly 16
//    transfers, values match test 1.
//  4 start held every cycle, RESTART_EN=0 -> one schedule of 16 then immediate second
//    schedule; RESTART_EN=1 -> restart after each start, key stays K1 (idx0).
//  5 rst asserted at idx 7 -> next cycle key_valid=0,busy=0,round_idx=0; new start
//    yields K1=1B02EFFC7072.
//  6 random keys/modes vs reference model (unrolled generator) over 1000 schedules.

Source files
------------

// File: rtl/des_pkg.sv
// DES key-schedule constants: per-round shift tables, PC-1/PC-2 bit maps, FSM states.
// Table entries use DES numbering: bit 1 is the MSB of the source vector.
package des_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Step 0 of decrypt needs no shift: the full encrypt rotation totals 28, i.e. identity.
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] amt,
                                        input logic right);
    logic [27:0] r;
    r = x;
    case ({right, amt})
      3'b001:  r = {x[26:0], x[27]};
      3'b010:  r = {x[25:0], x[27:26]};
      3'b101:  r = {x[0], x[27:1]};
      3'b110:  r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] shift_amt(input logic dec, input logic [3:0] step);
    return dec ? DEC_SHIFT[step] : ENC_SHIFT[step];
  endfunction

endpackage

// File: rtl/p_box_56_48.sv
// PC-2: compresses the 56-bit C/D state into a 48-bit round key.
// Purely combinational, no flow control.
module p_box_56_48
  import des_pkg::*;
(
  input  logic [55:0] i_dat,
  output logic [47:0] o_dat
);

  for (genvar gi = 0; gi < 48; gi++) begin : g_bit
    assign o_dat[47-gi] = i_dat[56-PC2[gi]];
  end

  logic w_unused_drop;
  assign w_unused_drop = ^{i_dat[47], i_dat[38], i_dat[34], i_dat[31],
                           i_dat[21], i_dat[18], i_dat[13], i_dat[2]};

endmodule

// File: rtl/p_box_64_56.sv
// PC-1: selects the 56 key bits from a 64-bit DES key, dropping the parity bits.
// Purely combinational, no flow control.
module p_box_64_56
  import des_pkg::*;
(
  input  logic [63:0] i_dat,
  output logic [55:0] o_dat
);

  for (genvar gi = 0; gi < 56; gi++) begin : g_bit
    assign o_dat[55-gi] = i_dat[64-PC1[gi]];
  end

  logic w_unused_parity;
  assign w_unused_parity = ^{i_dat[56], i_dat[48], i_dat[40], i_dat[32],
                             i_dat[24], i_dat[16], i_dat[8],  i_dat[0]};

endmodule

// File: rtl/des_key_sched_iter.sv
// Iterative DES key schedule, one round key per valid/ready transfer; first key 1 cycle after start.
// Key outputs hold while key_valid & !key_ready; decrypt walks the schedule backwards with right rotations.
module des_key_sched_iter
  import des_pkg::*;
#(
  parameter int RESTART_EN = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] init_key,
  input  logic        encrypt_decrypt,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        key_last,
  output logic        busy
);

  logic        r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_cnt;
  logic        r_dec;

  logic [55:0] w_pc1;
  logic        w_run;
  logic        w_xfer;
  logic        w_final;
  logic        w_load;
  logic [1:0]  w_amt_load;
  logic [1:0]  w_amt_step;

  p_box_64_56 u_pc1 (.i_dat(init_key),   .o_dat(w_pc1));
  p_box_56_48 u_pc2 (.i_dat({r_c, r_d}), .o_dat(round_key));

  assign w_run      = (r_state == ST_RUN);
  assign w_xfer     = w_run & key_ready;
  assign w_final    = w_xfer & (r_cnt == 4'd15);
  // A start landing on the final transfer chains the next schedule with no bubble.
  assign w_load     = start & (!w_run | (RESTART_EN != 0) | w_final);
  assign w_amt_load = shift_amt(encrypt_decrypt, 4'd0);
  assign w_amt_step = shift_amt(r_dec, r_cnt + 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
    end else if (w_load) begin
      r_state <= ST_RUN;
      r_c     <= rot28(w_pc1[55:28], w_amt_load, encrypt_decrypt);
      r_d     <= rot28(w_pc1[27:0],  w_amt_load, encrypt_decrypt);
      r_cnt   <= '0;
      r_dec   <= encrypt_decrypt;
    end else if (w_final) begin
      r_state <= ST_IDLE;
    end else if (w_xfer) begin
      r_cnt   <= r_cnt + 4'd1;
      r_c     <= rot28(r_c, w_amt_step, r_dec);
      r_d     <= rot28(r_d, w_amt_step, r_dec);
    end
  end

  assign key_valid = w_run;
  assign busy      = w_run;
  assign key_last  = w_run & (r_cnt == 4'd15);
  assign round_idx = r_dec ? (4'd15 - r_cnt) : r_cnt;

endmodule

// File: tb/tb_des_key_sched_iter.sv
// Bench for des_key_sched_iter: two instances (restart disabled/enabled) share stimulus,
// each checked every cycle against an unrolled DES key-schedule model.
module tb_des_key_sched_iter;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1  = 48'h1B02EFFC7072;
  localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

  localparam int TB_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int TB_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int TB_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] init_key;
  logic        encrypt_decrypt;
  logic        key_ready;

  logic        kv [2];
  logic [47:0] rk [2];
  logic [3:0]  ri [2];
  logic        kl [2];
  logic        bz [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  des_key_sched_iter #(.RESTART_EN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .init_key(init_key),
    .encrypt_decrypt(encrypt_decrypt), .key_ready(key_ready),
    .key_valid(kv[0]), .round_key(rk[0]), .round_idx(ri[0]),
    .key_last(kl[0]), .busy(bz[0]));

  des_key_sched_iter #(.RESTART_EN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .init_key(init_key),
    .encrypt_decrypt(encrypt_decrypt), .key_ready(key_ready),
    .key_valid(kv[1]), .round_key(rk[1]), .round_idx(ri[1]),
    .key_last(kl[1]), .busy(bz[1]));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Round key r (0 = K1) straight from the textbook: cumulative left shift of PC-1 halves, then PC-2.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
    logic [55:0] cd;
    logic [55:0] t;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] o;
    int tot;
    tot = 0;
    for (int i = 0; i <= r; i++) tot += TB_SH[i];
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-TB_PC1[i]];
    t = {cd[55:28], cd[55:28]} << tot;
    c = t[55:28];
    t = {cd[27:0], cd[27:0]} << tot;
    d = t[55:28];
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-TB_PC2[i]];
    return o;
  endfunction

  // Transaction-level model per instance: active flag, position in schedule, mode, captured key.
  logic        m_act [2];
  logic [3:0]  m_pos [2];
  logic        m_dec [2];
  logic [63:0] m_key [2];
  logic        chk_en = 1'b0;
  logic        mon_en = 1'b0;
  logic [47:0] xq [$];
  logic [47:0] enc_q [$];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_act[d] <= 1'b0;
        m_pos[d] <= 4'd0;
        m_dec[d] <= 1'b0;
      end else if (start && (!m_act[d] || d == 1 || (key_ready && m_pos[d] == 4'd15))) begin
        m_act[d] <= 1'b1;
        m_pos[d] <= 4'd0;
        m_dec[d] <= encrypt_decrypt;
        m_key[d] <= init_key;
      end else if (m_act[d] && key_ready) begin
        if (m_pos[d] == 4'd15) m_act[d] <= 1'b0;
        else m_pos[d] <= m_pos[d] + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int r;
        check($sformatf("d%0d valid", d), kv[d], m_act[d]);
        check($sformatf("d%0d busy", d), bz[d], m_act[d]);
        if (m_act[d]) begin
          r = m_dec[d] ? 15 - int'(m_pos[d]) : int'(m_pos[d]);
          check($sformatf("d%0d key", d), rk[d], ref_key(m_key[d], r));
          check($sformatf("d%0d idx", d), ri[d], r);
          check($sformatf("d%0d last", d), kl[d], m_pos[d] == 4'd15);
        end else begin
          check($sformatf("d%0d last idle", d), kl[d], 0);
        end
      end
      if (mon_en && kv[0] && key_ready) xq.push_back(rk[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int cyc;
    cyc = 0;
    while ((m_act[0] || m_act[1]) && cyc < 400) begin
      step();
      cyc++;
    end
    check({nm, " idle timeout"}, cyc < 400, 1);
  endtask

  task automatic pulse_start(input logic [63:0] k, input logic ed);
    init_key = k;
    encrypt_decrypt = ed;
    start = 1'b1;
    step();
    start = 1'b0;
    init_key = {$urandom, $urandom};
    encrypt_decrypt = ~ed;
  endtask

  initial begin
    int drops;
    int cyc;
    rst = 1'b1; start = 1'b0; init_key = '0; encrypt_decrypt = 1'b0; key_ready = 1'b0;
    step();
    chk_en = 1'b1;
    step(); step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst key", d), rk[d], 0);
      check($sformatf("d%0d rst idx", d), ri[d], 0);
      check($sformatf("d%0d rst valid", d), kv[d], 0);
      check($sformatf("d%0d rst busy", d), bz[d], 0);
      check($sformatf("d%0d rst last", d), kl[d], 0);
    end
    check("model K1", ref_key(KEY, 0), K1);
    check("model K16", ref_key(KEY, 15), K16);
    step();
    rst = 1'b0;

    // Encrypt, constant ready
    key_ready = 1'b1;
    xq.delete(); mon_en = 1'b1;
    pulse_start(KEY, 1'b0);
    @(negedge clk);
    check("enc first key", rk[0], K1);
    check("enc first idx", ri[0], 0);
    repeat (15) @(negedge clk);
    check("enc last key", rk[0], K16);
    check("enc last idx", ri[0], 15);
    check("enc last flag", kl[0], 1);
    @(negedge clk);
    check("enc busy after", bz[0], 0);
    mon_en = 1'b0;
    check("enc count", xq.size(), 16);
    enc_q = xq;

    // Decrypt, same key: reversed sequence
    xq.delete(); mon_en = 1'b1;
    step();
    pulse_start(KEY, 1'b1);
    @(negedge clk);
    check("dec first key", rk[0], K16);
    check("dec first idx", ri[0], 15);
    repeat (15) @(negedge clk);
    check("dec last key", rk[0], K1);
    check("dec last idx", ri[0], 0);
    check("dec last flag", kl[0], 1);
    @(negedge clk);
    mon_en = 1'b0;
    check("dec count", xq.size(), 16);
    if (xq.size() == 16 && enc_q.size() == 16)
      for (int i = 0; i < 16; i++) check($sformatf("dec rev %0d", i), xq[i], enc_q[15-i]);

    // Backpressure, ready ~30%
    xq.delete(); mon_en = 1'b1;
    step();
    key_ready = ($urandom_range(0, 99) < 30);
    pulse_start(KEY, 1'b0);
    cyc = 0;
    while (m_act[0] && cyc < 400) begin
      key_ready = ($urandom_range(0, 99) < 30);
      step();
      cyc++;
    end
    check("bp timeout", cyc < 400, 1);
    mon_en = 1'b0;
    check("bp count", xq.size(), 16);
    if (xq.size() == 16 && enc_q.size() == 16)
      for (int i = 0; i < 16; i++) check($sformatf("bp key %0d", i), xq[i], enc_q[i]);
    key_ready = 1'b1;
    wait_idle("bp");

    // Start held every cycle
    init_key = KEY; encrypt_decrypt = 1'b0; start = 1'b1;
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!kv[0]) drops++;
    end
    check("hold no drop", drops, 0);
    check("hold norestart idx", ri[0], 7);
    check("hold restart key", rk[1], K1);
    check("hold restart idx", ri[1], 0);
    start = 1'b0;
    wait_idle("hold");

    // Reset mid-run at idx 7, with start asserted
    pulse_start(KEY, 1'b0);
    cyc = 0;
    while (ri[0] != 4'd7 && cyc < 40) begin
      step();
      cyc++;
    end
    check("rst reach idx7", ri[0], 7);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d midrst valid", d), kv[d], 0);
      check($sformatf("d%0d midrst busy", d), bz[d], 0);
      check($sformatf("d%0d midrst idx", d), ri[d], 0);
    end
    step();
    pulse_start(KEY, 1'b0);
    @(negedge clk);
    check("post rst K1", rk[0], K1);
    wait_idle("post rst");

    // Random keys, modes, ready, stray starts
    for (int s = 0; s < 1000; s++) begin
      key_ready = ($urandom_range(0, 99) < 60);
      pulse_start({$urandom, $urandom}, 1'($urandom_range(0, 1)));
      cyc = 0;
      while ((m_act[0] || m_act[1]) && cyc < 400) begin
        key_ready = ($urandom_range(0, 99) < 60);
        init_key = {$urandom, $urandom};
        encrypt_decrypt = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 39) == 0);
        step();
        cyc++;
      end
      start = 1'b0;
      check("rand timeout", cyc < 400, 1);
      wait_idle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
